// File: rtl/core_host_seq.sv
// core_host_seq: host-side sequencer around the systolic core.
//   Loads ACT_LEN activation words then W_LEN weight words from a valid/ready stream into the
//   core's ACT/W SRAMs (dut_cl_sel=1), hands the SRAMs to the corelet (dut_cl_sel=0), pulses
//   seq_begin, waits for seq_done, reclaims the SRAMs and streams OP_LEN 128-bit words read
//   from OP SRAM (starting at OP_BASE) out over a valid/ready port.
// Ports:
//   clk, reset (async, active-low), start/busy/done/err  - control and status
//   in_valid/in_ready/in_data                             - 32-bit load stream
//   dut_ACT_* / dut_W_*                                   - ACT and W SRAM write ports
//   dut_cl_sel, seq_begin, seq_done                       - corelet handoff
//   dut_OP_*                                              - OP SRAM read port
//   out_valid/out_ready/out_data                          - 128-bit result stream
// Optional feature: define CORE_HOST_TIMEOUT_EN to add a WAIT-state watchdog of TIMEOUT_CYC
// cycles that sets err and ends the sequence without the read phase.
module core_host_seq #(
  parameter int unsigned ACT_LEN     = 108,
  parameter int unsigned W_LEN       = 108,
  parameter int unsigned OP_LEN      = 8,
  parameter int unsigned OP_BASE     = 0,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         err,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  output logic [31:0]  dut_ACT_d,
  output logic [6:0]   dut_ACT_addr,
  output logic         dut_ACT_cen,
  output logic         dut_ACT_wen,
  output logic [31:0]  dut_W_d,
  output logic [6:0]   dut_W_addr,
  output logic         dut_W_cen,
  output logic         dut_W_wen,
  output logic         dut_cl_sel,
  output logic         seq_begin,
  input  logic         seq_done,
  output logic [8:0]   dut_OP_addr,
  output logic         dut_OP_cen,
  output logic         dut_OP_wen,
  output logic [127:0] dut_OP_d,
  input  logic [127:0] dut_OP_q,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam logic [3:0] StIdle    = 4'd0;
  localparam logic [3:0] StLoadAct = 4'd1;
  localparam logic [3:0] StLoadW   = 4'd2;
  localparam logic [3:0] StHandoff = 4'd3;
  localparam logic [3:0] StKick    = 4'd4;
  localparam logic [3:0] StWait    = 4'd5;
  localparam logic [3:0] StReclaim = 4'd6;
  localparam logic [3:0] StRdReq   = 4'd7;
  localparam logic [3:0] StRdCap   = 4'd8;
  localparam logic [3:0] StHold    = 4'd9;
  localparam logic [3:0] StFin     = 4'd10;

  logic [3:0]   state_q, state_d;
  logic [8:0]   cnt_q, cnt_d;
  logic         out_valid_q, out_valid_d;
  logic [127:0] out_data_q, out_data_d;
  logic         timeout;

`ifdef CORE_HOST_TIMEOUT_EN
  logic [15:0] wd_q;
  logic        err_q;

  assign timeout = (state_q == StWait) && !seq_done && (wd_q == 16'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      // Cleared in KICK so the count starts at zero on the first WAIT cycle.
      if (state_q == StKick) wd_q <= '0;
      else if (state_q == StWait) wd_q <= wd_q + 16'd1;
      if ((state_q == StIdle) && start) err_q <= 1'b0;
      else if (timeout) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic [31:0] unused_timeout_cyc;
  assign unused_timeout_cyc = TIMEOUT_CYC;
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d   = '0;
          state_d = StLoadAct;
        end
      end
      StLoadAct: begin
        if (in_valid) begin
          if (cnt_q == 9'(ACT_LEN - 1)) begin
            cnt_d   = '0;
            state_d = StLoadW;
          end else begin
            cnt_d = cnt_q + 9'd1;
          end
        end
      end
      StLoadW: begin
        if (in_valid) begin
          if (cnt_q == 9'(W_LEN - 1)) begin
            cnt_d   = '0;
            state_d = StHandoff;
          end else begin
            cnt_d = cnt_q + 9'd1;
          end
        end
      end
      StHandoff: state_d = StKick;
      StKick:    state_d = StWait;
      StWait: begin
        if (seq_done) state_d = StReclaim;
        else if (timeout) state_d = StFin;
      end
      StReclaim: begin
        cnt_d   = '0;
        state_d = StRdReq;
      end
      StRdReq: state_d = StRdCap;
      StRdCap: begin
        // OP SRAM data is valid the cycle after the cen=0 request.
        out_data_d  = dut_OP_q;
        out_valid_d = 1'b1;
        state_d     = StHold;
      end
      StHold: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          cnt_d       = cnt_q + 9'd1;
          state_d     = (cnt_q == 9'(OP_LEN - 1)) ? StFin : StRdReq;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Outputs decode from registered state so an async reset clears them at once.
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StFin);
  assign in_ready   = (state_q == StLoadAct) || (state_q == StLoadW);
  assign dut_cl_sel = !((state_q == StHandoff) || (state_q == StKick) || (state_q == StWait));
  assign seq_begin  = (state_q == StKick);

  assign dut_ACT_d    = in_data;
  assign dut_ACT_cen  = (state_q == StLoadAct) ? ~in_valid : 1'b1;
  assign dut_ACT_wen  = (state_q == StLoadAct) ? ~in_valid : 1'b1;
  assign dut_ACT_addr = (state_q == StLoadAct) ? cnt_q[6:0] : 7'd0;

  assign dut_W_d    = in_data;
  assign dut_W_cen  = (state_q == StLoadW) ? ~in_valid : 1'b1;
  assign dut_W_wen  = (state_q == StLoadW) ? ~in_valid : 1'b1;
  assign dut_W_addr = (state_q == StLoadW) ? cnt_q[6:0] : 7'd0;

  assign dut_OP_cen  = (state_q != StRdReq);
  assign dut_OP_addr = (state_q == StRdReq) ? 9'(OP_BASE) + cnt_q : 9'd0;
  assign dut_OP_wen  = 1'b1;
  assign dut_OP_d    = '0;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_core_host_seq.sv
module tb_core_host_seq;

  localparam int unsigned ActLen  = 4;
  localparam int unsigned WLen    = 4;
  localparam int unsigned OpLen   = 2;
  localparam int unsigned OpBase  = 5;
  localparam int unsigned TmoCyc  = 20;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         busy, done, err;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic [31:0]  dut_ACT_d, dut_W_d;
  logic [6:0]   dut_ACT_addr, dut_W_addr;
  logic         dut_ACT_cen, dut_ACT_wen, dut_W_cen, dut_W_wen;
  logic         dut_cl_sel, seq_begin;
  logic         seq_done = 1'b0;
  logic [8:0]   dut_OP_addr;
  logic         dut_OP_cen, dut_OP_wen;
  logic [127:0] dut_OP_d;
  logic [127:0] op_q = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_data;

  core_host_seq #(
    .ACT_LEN    (ActLen),
    .W_LEN      (WLen),
    .OP_LEN     (OpLen),
    .OP_BASE    (OpBase),
    .TIMEOUT_CYC(TmoCyc)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .dut_ACT_d   (dut_ACT_d),
    .dut_ACT_addr(dut_ACT_addr),
    .dut_ACT_cen (dut_ACT_cen),
    .dut_ACT_wen (dut_ACT_wen),
    .dut_W_d     (dut_W_d),
    .dut_W_addr  (dut_W_addr),
    .dut_W_cen   (dut_W_cen),
    .dut_W_wen   (dut_W_wen),
    .dut_cl_sel  (dut_cl_sel),
    .seq_begin   (seq_begin),
    .seq_done    (seq_done),
    .dut_OP_addr (dut_OP_addr),
    .dut_OP_cen  (dut_OP_cen),
    .dut_OP_wen  (dut_OP_wen),
    .dut_OP_d    (dut_OP_d),
    .dut_OP_q    (op_q),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_begin = 0;
  int n_done = 0;
  int hold_cnt = 0;
  int begin_cyc = 0;
  int done_cyc = 0;
  bit seen_begin = 1'b0;
  bit prev_hs = 1'b0;
  bit core_en = 1'b1;
  bit exp_err = 1'b0;

  logic [38:0]  exp_act_q[$];
  logic [38:0]  exp_w_q[$];
  logic [8:0]   exp_op_q[$];
  logic [127:0] exp_out_q[$];
  logic [127:0] op_mem[512];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // OP SRAM model: one-cycle read latency.
  always @(posedge clk) if (!dut_OP_cen) op_q <= op_mem[dut_OP_addr];

  // Stub core: seq_done pulse 6 cycles after seq_begin.
  always begin
    @(negedge clk);
    if (reset && seq_begin && core_en) begin
      repeat (6) @(posedge clk);
      #1 seq_done = 1'b1;
      @(posedge clk);
      #1 seq_done = 1'b0;
    end
  end

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      if (!dut_ACT_cen) begin
        chk("act_wen", dut_ACT_wen, 1'b0);
        if (exp_act_q.size() == 0) chk("act_extra_write", 1'b1, 1'b0);
        else chk("act_write", {dut_ACT_addr, dut_ACT_d}, exp_act_q.pop_front());
      end
      if (!dut_W_cen) begin
        chk("w_wen", dut_W_wen, 1'b0);
        if (exp_w_q.size() == 0) chk("w_extra_write", 1'b1, 1'b0);
        else chk("w_write", {dut_W_addr, dut_W_d}, exp_w_q.pop_front());
      end
      if (in_ready && !in_valid) chk("idle_cen", {dut_ACT_cen, dut_W_cen}, 2'b11);
      if (seq_begin) begin
        n_begin++;
        seen_begin = 1'b1;
        begin_cyc  = cyc;
        chk("begin_clsel", dut_cl_sel, 1'b0);
      end
      if (!dut_OP_cen) begin
        chk("op_clsel", dut_cl_sel, 1'b1);
        chk("op_wen", dut_OP_wen, 1'b1);
        if (exp_op_q.size() == 0) chk("op_extra_read", 1'b1, 1'b0);
        else chk("op_addr", dut_OP_addr, exp_op_q.pop_front());
      end
      if (prev_hs) chk("valid_drop", out_valid, 1'b0);
      prev_hs = 1'b0;
      if (out_valid) begin
        chk("hold_no_read", dut_OP_cen, 1'b1);
        if (exp_out_q.size() == 0) chk("out_extra", 1'b1, 1'b0);
        else chk("out_data", out_data, exp_out_q[0]);
        if (out_ready) begin
          if (exp_out_q.size() != 0) void'(exp_out_q.pop_front());
          prev_hs = 1'b1;
        end else begin
          hold_cnt++;
        end
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
        chk("done_err", err, exp_err);
        chk("done_clsel", dut_cl_sel, 1'b1);
      end
    end
  end

  task automatic run_seq(input bit gaps, input bit poke, input bit stall, input bit do_rst,
                         input bit tmo);
    bit pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int k = 0;
    int p = 0;
    int t = 0;
    bit poked_wait = 1'b0;
    bit drv;
    n_begin = 0; n_done = 0; hold_cnt = 0; seen_begin = 1'b0;
    exp_err = tmo;
    if (!do_rst && !tmo) begin
      for (int i = 0; i < OpLen; i++) begin
        exp_op_q.push_back(9'(OpBase + i));
        exp_out_q.push_back(op_mem[OpBase + i]);
      end
    end
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (k < ActLen + WLen) begin
      start = 1'b0;
      drv = !gaps || pat[p % 7];
      if (drv) begin
        in_valid = 1'b1;
        in_data  = (k < ActLen) ? 32'hA0 + 32'(k) : 32'hB0 + 32'(k - ActLen);
        chk("in_ready", in_ready, 1'b1);
        if (do_rst && k == ActLen + 2) begin
          #1 reset = 1'b0;
          #1;
          chk("rst_status", {busy, done, err, in_ready, seq_begin, out_valid}, 6'b0);
          chk("rst_clsel", dut_cl_sel, 1'b1);
          chk("rst_cen_wen", {dut_ACT_cen, dut_ACT_wen, dut_W_cen, dut_W_wen, dut_OP_cen},
              5'b11111);
          chk("rst_addr", {dut_ACT_addr, dut_W_addr, dut_OP_addr}, 23'd0);
          chk("rst_out_data", out_data, 128'd0);
          in_valid = 1'b0;
          exp_act_q.delete();
          exp_w_q.delete();
          @(posedge clk); #1 reset = 1'b1;
          return;
        end
        if (k < ActLen) exp_act_q.push_back({7'(k), in_data});
        else exp_w_q.push_back({7'(k - ActLen), in_data});
        if (poke && k == ActLen + 1) start = 1'b1;
        k++;
      end else begin
        in_valid = 1'b0;
      end
      p++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    while (n_done == 0 && t < 400) begin
      start = 1'b0;
      if (poke && seen_begin && !poked_wait) begin
        start      = 1'b1;
        poked_wait = 1'b1;
      end
      out_ready = !(stall && hold_cnt < 10);
      @(posedge clk); #1;
      t++;
    end
    start     = 1'b0;
    out_ready = 1'b1;
    chk("done_reached", t < 400, 1'b1);
    chk("done_count", n_done, 1);
    chk("begin_count", n_begin, 1);
    chk("pending_writes", exp_act_q.size() + exp_w_q.size(), 0);
    chk("pending_reads", exp_op_q.size(), 0);
    chk("pending_out", exp_out_q.size(), 0);
    if (stall) chk("stall_cycles", hold_cnt, 10);
    if (tmo) chk("tmo_latency", (done_cyc - begin_cyc >= 18) && (done_cyc - begin_cyc <= 24),
                 1'b1);
    @(posedge clk); #1;
    chk("idle_after", busy, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) op_mem[i] = {4{32'h5EED_0000 + 32'(i * 17)}};
    #3;
    chk("reset_status", {busy, done, err, in_ready, seq_begin, out_valid}, 6'b0);
    chk("reset_clsel", dut_cl_sel, 1'b1);
    chk("reset_cen", {dut_ACT_cen, dut_W_cen, dut_OP_cen}, 3'b111);
    chk("reset_out_data", out_data, 128'd0);
    @(posedge clk); #1 reset = 1'b1;
    run_seq(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);  // basic sequence
    run_seq(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);  // input gaps
    run_seq(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);  // output backpressure
    run_seq(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);  // stray start pulses
    run_seq(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);  // reset in LOAD_W
    run_seq(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);  // restart from address 0
`ifdef CORE_HOST_TIMEOUT_EN
    core_en = 1'b0;
    run_seq(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("err_held", err, 1'b1);
    core_en = 1'b1;
    run_seq(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got time %0t", $time);
    $fatal(1, "global timeout");
  end

endmodule
